// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver: HEADER, CMD, LEN, LEN payload bytes, checksum.
// Streams the payload, reports frame OK/error, and pulses the receiver's ready-clear.
module uart_frame_parser #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    output logic [7:0] cmd,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic [7:0] pl_index,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK} state_t;

    state_t      state_q;
    logic        rx_rdy_prev_q;
    logic        rx_rdy_clr_q;
    logic [7:0]  cmd_q;
    logic [7:0]  pl_data_q;
    logic        pl_valid_q;
    logic [7:0]  pl_index_q;
    logic        frame_ok_q;
    logic        frame_err_q;
    logic [1:0]  err_code_q;
    logic [7:0]  sum_q;
    logic [7:0]  cnt_q;
    logic [7:0]  idx_q;
    logic [15:0] tmo_q;

    logic       byte_acc;
    logic       tmo_hit;
    logic [7:0] sum_nx;
    logic [7:0] idx_nx;

    // The receiver's flag is sticky, so only its rising edge marks a new byte.
    assign byte_acc = rx_rdy && !rx_rdy_prev_q;
    assign tmo_hit  = (state_q != S_IDLE) && (tmo_q == TMO_LAST);
    assign sum_nx   = sum_q + rx_data;
    assign idx_nx   = idx_q + 8'd1;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rx_rdy_prev_q <= 1'b0;
            rx_rdy_clr_q  <= 1'b0;
            cmd_q         <= 8'd0;
            pl_data_q     <= 8'd0;
            pl_valid_q    <= 1'b0;
            pl_index_q    <= 8'd0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            sum_q         <= 8'd0;
            cnt_q         <= 8'd0;
            idx_q         <= 8'd0;
            tmo_q         <= 16'd0;
        end else begin
            rx_rdy_prev_q <= rx_rdy;
            rx_rdy_clr_q  <= byte_acc;
            pl_valid_q    <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            if (byte_acc || state_q == S_IDLE) begin
                tmo_q <= 16'd0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (byte_acc) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data == HEADER) state_q <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_q   <= rx_data;
                        sum_q   <= rx_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'b01;
                            state_q     <= S_IDLE;
                        end else begin
                            sum_q   <= sum_nx;
                            cnt_q   <= rx_data;
                            idx_q   <= 8'd0;
                            state_q <= (rx_data == 8'd0) ? S_CHK : S_PAY;
                        end
                    end
                    S_PAY: begin
                        pl_data_q  <= rx_data;
                        pl_index_q <= idx_q;
                        pl_valid_q <= 1'b1;
                        sum_q      <= sum_nx;
                        idx_q      <= idx_nx;
                        if (idx_nx == cnt_q) state_q <= S_CHK;
                    end
                    S_CHK: begin
                        if (rx_data == sum_q) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'b10;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (tmo_hit) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'b11;
                state_q     <= S_IDLE;
                tmo_q       <= 16'd0;
            end
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign cmd        = cmd_q;
    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_index   = pl_index_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed and random byte streams checked against
// a frame-scanning reference model and an event monitor.
module tb_uart_frame_parser;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 200;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_rdy  = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_rdy_clr;
    logic [7:0] cmd;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic [7:0] pl_index;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_parser #(
        .HEADER(8'hAA), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_rdy_clr(rx_rdy_clr), .cmd(cmd), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_index(pl_index), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );

    always #10 clk_50m = ~clk_50m;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sent_q[$];
    int         exp_clr = 0, exp_ok = 0, exp_err = 0;
    logic [1:0] exp_code = 2'b00;
    logic [7:0] exp_cmd  = 8'd0;
    logic [7:0] exp_pd[$], exp_pi[$];

    int         mon_clr = 0, mon_ok = 0, mon_err = 0;
    logic [7:0] mon_pd[$], mon_pi[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_50m) begin
        if (rx_rdy_clr === 1'b1) mon_clr++;
        if (pl_valid === 1'b1) begin
            mon_pd.push_back(pl_data);
            mon_pi.push_back(pl_index);
        end
        if (frame_ok === 1'b1) mon_ok++;
        if (frame_err === 1'b1) mon_err++;
        if (frame_ok === 1'b1 || frame_err === 1'b1)
            chk("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
    end

    // One byte: flag up for h edges, then down for g edges (accept-to-accept gap h+g).
    task automatic send_byte(input logic [7:0] b, input int h, input int g);
        @(negedge clk_50m);
        rx_data = b;
        rx_rdy  = 1'b1;
        repeat (h) @(negedge clk_50m);
        rx_rdy = 1'b0;
        repeat (g - 1) @(negedge clk_50m);
        sent_q.push_back(b);
        exp_clr++;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[k]) send_byte(q[k], 1, 2);
    endtask

    // Scans the byte stream for frames; truncated frames yield only what was received.
    task automatic model_run();
        int i, n, len, sum;
        bit trunc;
        i = 0;
        n = sent_q.size();
        while (i < n) begin
            if (sent_q[i] != 8'hAA) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            exp_cmd = sent_q[i+1];
            if (i + 2 >= n) break;
            len = int'(sent_q[i+2]);
            if (len > MAX_LEN) begin
                exp_err++;
                exp_code = 2'b01;
                i += 3;
                continue;
            end
            sum = int'(sent_q[i+1]) + len;
            trunc = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (i + 3 + k >= n) begin
                    trunc = 1'b1;
                    break;
                end
                exp_pd.push_back(sent_q[i+3+k]);
                exp_pi.push_back(8'(k));
                sum += int'(sent_q[i+3+k]);
            end
            if (trunc || i + 3 + len >= n) break;
            if (int'(sent_q[i+3+len]) == sum % 256) exp_ok++;
            else begin
                exp_err++;
                exp_code = 2'b10;
            end
            i += 4 + len;
        end
        sent_q.delete();
    endtask

    task automatic check_step(input string nm);
        repeat (4) @(negedge clk_50m);
        @(posedge clk_50m);
        #1;
        model_run();
        chk({nm, ".clr_pulses"}, mon_clr, exp_clr);
        chk({nm, ".pl_count"}, mon_pd.size(), exp_pd.size());
        for (int k = 0; k < exp_pd.size() && k < mon_pd.size(); k++) begin
            chk($sformatf("%s.pl_data[%0d]", nm, k), mon_pd[k], exp_pd[k]);
            chk($sformatf("%s.pl_index[%0d]", nm, k), mon_pi[k], exp_pi[k]);
        end
        chk({nm, ".frame_ok"}, mon_ok, exp_ok);
        chk({nm, ".frame_err"}, mon_err, exp_err);
        chk({nm, ".err_code"}, err_code, exp_code);
        chk({nm, ".cmd"}, cmd, exp_cmd);
        mon_clr = 0; mon_ok = 0; mon_err = 0;
        exp_clr = 0; exp_ok = 0; exp_err = 0;
        mon_pd.delete(); mon_pi.delete(); exp_pd.delete(); exp_pi.delete();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".rx_rdy_clr"}, rx_rdy_clr, 0);
        chk({nm, ".cmd"}, cmd, 0);
        chk({nm, ".pl_data"}, pl_data, 0);
        chk({nm, ".pl_valid"}, pl_valid, 0);
        chk({nm, ".pl_index"}, pl_index, 0);
        chk({nm, ".frame_ok"}, frame_ok, 0);
        chk({nm, ".frame_err"}, frame_err, 0);
        chk({nm, ".err_code"}, err_code, 0);
    endtask

    initial begin
        logic [7:0] seq[$];
        int njunk, len, sum, h, g;
        logic [7:0] b, c;

        repeat (3) @(negedge clk_50m);
        @(posedge clk_50m);
        #1;
        check_zero("reset");
        @(negedge clk_50m);
        rst_n = 1'b1;

        seq = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89};
        send_seq(seq);
        check_step("good_frame");

        seq = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h88};
        send_seq(seq);
        check_step("bad_checksum");

        seq = '{8'hAA, 8'h05, 8'h11};
        send_seq(seq);
        check_step("len_over");
        seq = '{8'hAA, 8'h05, 8'h00, 8'h05};
        send_seq(seq);
        check_step("len_zero");

        seq = '{8'hAA, 8'h06, 8'h10};
        sum = 8'h16;
        for (int k = 0; k < MAX_LEN; k++) begin
            seq.push_back(8'(k * 7 + 1));
            sum += k * 7 + 1;
        end
        seq.push_back(8'(sum % 256));
        send_seq(seq);
        check_step("len_max");

        seq = '{8'hAA, 8'h07};
        send_seq(seq);
        model_run();
        repeat (TMO + 5) @(negedge clk_50m);
        exp_err++;
        exp_code = 2'b11;
        seq = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
        send_seq(seq);
        check_step("timeout");

        send_byte(8'hAA, 1, 2);
        send_byte(8'h07, 1, TMO - 1);
        send_byte(8'h00, 1, 2);
        send_byte(8'h07, 1, 2);
        check_step("gap_at_limit");

        send_byte(8'hAA, 1, 2);
        send_byte(8'h09, 1, TMO);
        model_run();
        exp_err++;
        exp_code = 2'b11;
        send_byte(8'h00, 1, 2);
        send_byte(8'h09, 1, 2);
        check_step("gap_over_limit");

        send_byte(8'h00, 20, 2);
        send_byte(8'hFF, 1, 2);
        send_byte(8'h12, 1, 2);
        seq = '{8'hAA, 8'h21, 8'h01, 8'h5A, 8'h7C};
        send_seq(seq);
        check_step("held_rdy_junk");

        seq = '{8'hAA, 8'h10, 8'h02, 8'h33};
        send_seq(seq);
        model_run();
        @(negedge clk_50m);
        rst_n = 1'b0;
        @(posedge clk_50m);
        #1;
        check_zero("mid_reset");
        exp_cmd  = 8'd0;
        exp_code = 2'b00;
        @(negedge clk_50m);
        rst_n = 1'b1;
        seq = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89};
        send_seq(seq);
        check_step("after_reset");

        for (int f = 0; f < 40; f++) begin
            h = $urandom_range(1, 3);
            g = $urandom_range(1, 4);
            njunk = $urandom_range(0, 2);
            for (int j = 0; j < njunk; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hAA) b = 8'h55;
                send_byte(b, h, g);
            end
            c   = 8'($urandom_range(0, 255));
            len = $urandom_range(0, MAX_LEN + 3);
            send_byte(8'hAA, h, g);
            send_byte(c, h, g);
            send_byte(8'(len), h, g);
            if (len <= MAX_LEN) begin
                sum = int'(c) + len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    sum += int'(b);
                    send_byte(b, h, g);
                end
                b = 8'(sum % 256);
                if ($urandom_range(0, 3) == 0) b = b ^ 8'($urandom_range(1, 255));
                send_byte(b, h, g);
            end
            check_step($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
